// File: rtl/keypad_hex_entry_pkg.sv
// Shared definitions for the keypad hex entry block: FSM encoding, key map and
// default timing parameters.
package keypad_hex_entry_pkg;

   localparam int unsigned SCAN_DIV_DEF = 1000;
   localparam int unsigned DEB_CNT_DEF  = 8;
   localparam int unsigned NUM_KEYS     = 16;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HELD = 1'b1
   } kp_state_t;

   // Index is 4*row + col; value is the hex code printed on the key.
   localparam logic [3:0] KEY_MAP [NUM_KEYS] = '{
      4'h1, 4'h2, 4'h3, 4'hA,
      4'h4, 4'h5, 4'h6, 4'hB,
      4'h7, 4'h8, 4'h9, 4'hC,
      4'hE, 4'h0, 4'hF, 4'hD
   };

endpackage

// File: rtl/keypad_hex_entry_kp_scan.sv
// Keypad column scanner: synchronises the rows, rotates the active-low column
// drive every SCAN_DIV cycles and assembles a 16-bit pressed-key snapshot.
//   clk          system clock
//   i_clr        synchronous active-high reset
//   i_row        keypad rows, active-low, asynchronous
//   o_col        column drive, exactly one bit low
//   o_snap       snapshot, bit 4*c+r set when row r of column c is pressed
//   o_scan_done  one-cycle strobe when o_snap holds a complete scan
module kp_scan
   import keypad_hex_entry_pkg::*;
#(
   parameter int unsigned SCAN_DIV = SCAN_DIV_DEF
) (
   input  logic        clk,
   input  logic        i_clr,
   input  logic [3:0]  i_row,
   output logic [3:0]  o_col,
   output logic [15:0] o_snap,
   output logic        o_scan_done
);

   localparam int unsigned DIV_W = $clog2(SCAN_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

   logic [3:0]       r_row_meta;
   logic [3:0]       r_row_sync;
   logic [DIV_W-1:0] r_div;
   logic [1:0]       r_col_idx;
   logic [3:0]       r_col;
   logic [15:0]      r_snap;
   logic             r_scan_done;
   logic             w_tc;
   logic [3:0]       w_pressed;

   assign w_tc      = (r_div == DIV_LAST);
   assign w_pressed = ~r_row_sync;

   // Synchroniser resets to "no key" so reset never fakes a press.
   always_ff @(posedge clk) begin
      if (i_clr) begin
         r_row_meta  <= 4'hF;
         r_row_sync  <= 4'hF;
         r_div       <= '0;
         r_col_idx   <= 2'd0;
         r_col       <= 4'b1110;
         r_snap      <= '0;
         r_scan_done <= 1'b0;
      end else begin
         r_row_meta  <= i_row;
         r_row_sync  <= r_row_meta;
         r_scan_done <= w_tc && (r_col_idx == 2'd3);
         if (w_tc) begin
            // Sample at the end of the window so the sync chain has settled.
            r_div                           <= '0;
            r_snap[{r_col_idx, 2'b00} +: 4] <= w_pressed;
            r_col                           <= {r_col[2:0], r_col[3]};
            r_col_idx                       <= r_col_idx + 2'd1;
         end else begin
            r_div <= r_div + DIV_W'(1);
         end
      end
   end

   assign o_col       = r_col;
   assign o_snap      = r_snap;
   assign o_scan_done = r_scan_done;

endmodule

// File: rtl/keypad_hex_entry.sv
// Keypad hex entry: scans and debounces a 4x4 keypad and shifts each accepted
// key code into a 32-bit word.
//   clk        system clock
//   clr        synchronous active-high reset
//   row        keypad rows, active-low, asynchronous
//   col        keypad columns, exactly one bit low
//   value      entered word, newest digit in value[3:0]
//   key_code   code of the last accepted key
//   key_valid  one-cycle pulse per accepted key
//   digit_cnt  digits entered since reset, saturating at 8
module keypad_hex_entry
   import keypad_hex_entry_pkg::*;
#(
   parameter int unsigned SCAN_DIV = SCAN_DIV_DEF,
   parameter int unsigned DEB_CNT  = DEB_CNT_DEF
) (
   input  logic        clk,
   input  logic        clr,
   input  logic [3:0]  row,
   output logic [3:0]  col,
   output logic [31:0] value,
   output logic [3:0]  key_code,
   output logic        key_valid,
   output logic [3:0]  digit_cnt
);

   localparam int unsigned CNT_W = $clog2(DEB_CNT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CNT);
   localparam logic [3:0] DIGITS_MAX = 4'd8;

   logic [15:0]      w_snap;
   logic             w_scan_done;
   logic [15:0]      r_prev_snap;
   logic [CNT_W-1:0] r_stable_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [15:0]      r_stable;
   logic             r_stable_upd;
   kp_state_t        r_state;
   kp_state_t        w_state_nxt;
   logic             w_emit;
   logic [4:0]       w_ones;
   logic [3:0]       w_idx;
   logic [3:0]       w_code;
   logic [31:0]      r_value;
   logic [3:0]       r_key_code;
   logic             r_key_valid;
   logic [3:0]       r_digit_cnt;

   kp_scan #(
      .SCAN_DIV (SCAN_DIV)
   ) u_scan (
      .clk         (clk),
      .i_clr       (clr),
      .i_row       (row),
      .o_col       (col),
      .o_snap      (w_snap),
      .o_scan_done (w_scan_done)
   );

   // Stability counter: any change between full scans restarts it.
   always_comb begin
      w_cnt_nxt = '0;
      if (w_snap == r_prev_snap) begin
         w_cnt_nxt = (r_stable_cnt == CNT_MAX) ? r_stable_cnt : r_stable_cnt + CNT_W'(1);
      end
   end

   // Debounce: accept the snapshot once it has been stable for DEB_CNT scans.
   always_ff @(posedge clk) begin
      if (clr) begin
         r_prev_snap  <= '0;
         r_stable_cnt <= '0;
         r_stable     <= '0;
         r_stable_upd <= 1'b0;
      end else begin
         r_stable_upd <= 1'b0;
         if (w_scan_done) begin
            r_prev_snap  <= w_snap;
            r_stable_cnt <= w_cnt_nxt;
            if (w_cnt_nxt == CNT_MAX) begin
               r_stable     <= w_snap;
               r_stable_upd <= 1'b1;
            end
         end
      end
   end

   // Popcount and position of the pressed key in the accepted state.
   always_comb begin
      w_ones = '0;
      w_idx  = '0;
      for (int i = 0; i < 16; i++) begin
         if (r_stable[i]) begin
            w_ones = w_ones + 5'd1;
            w_idx  = 4'(i);
         end
      end
      // Snapshot bit is 4*c+r, key map index is 4*r+c.
      w_code = KEY_MAP[{w_idx[1:0], w_idx[3:2]}];
   end

   // FSM next state: emit on a single key from IDLE, wait for full release.
   always_comb begin
      w_state_nxt = r_state;
      w_emit      = 1'b0;
      if (r_stable_upd) begin
         case (r_state)
            ST_IDLE: begin
               if (w_ones == 5'd1) begin
                  w_emit      = 1'b1;
                  w_state_nxt = ST_HELD;
               end
            end
            ST_HELD: begin
               if (r_stable == '0) begin
                  w_state_nxt = ST_IDLE;
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (clr) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Entry shift register and output pulse.
   always_ff @(posedge clk) begin
      if (clr) begin
         r_value     <= '0;
         r_key_code  <= '0;
         r_key_valid <= 1'b0;
         r_digit_cnt <= '0;
      end else begin
         r_key_valid <= w_emit;
         if (w_emit) begin
            r_key_code <= w_code;
            r_value    <= {r_value[27:0], w_code};
            if (r_digit_cnt != DIGITS_MAX) begin
               r_digit_cnt <= r_digit_cnt + 4'd1;
            end
         end
      end
   end

   assign value     = r_value;
   assign key_code  = r_key_code;
   assign key_valid = r_key_valid;
   assign digit_cnt = r_digit_cnt;

endmodule

// File: tb/tb_keypad_hex_entry.sv
// Self-checking bench for keypad_hex_entry with a behavioural keypad model.
module tb_keypad_hex_entry;

   localparam int unsigned SDIV = 4;
   localparam int unsigned DEB  = 3;
   localparam int unsigned SCAN = 4 * SDIV;

   logic        clk;
   logic        clr;
   logic [3:0]  row;
   logic [3:0]  col;
   logic [31:0] value;
   logic [3:0]  key_code;
   logic        key_valid;
   logic [3:0]  digit_cnt;

   logic [15:0] keys;       // pressed keys, bit 4*r+c
   logic [3:0]  exp_q[$];   // expected key codes, in order
   logic [31:0] m_value;
   logic [3:0]  m_cnt;
   int          n_cmp;
   int          n_bad;

   typedef struct {
      logic [15:0] keys;
      int unsigned press_scans;
      int unsigned rel_scans;
      logic        emit;
      logic [3:0]  code;
   } vec_t;

   vec_t tbl[10];

   keypad_hex_entry #(
      .SCAN_DIV (SDIV),
      .DEB_CNT  (DEB)
   ) dut (
      .clk       (clk),
      .clr       (clr),
      .row       (row),
      .col       (col),
      .value     (value),
      .key_code  (key_code),
      .key_valid (key_valid),
      .digit_cnt (digit_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Keypad: a pressed key pulls its row low while its column is driven low.
   always_comb begin
      row = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (keys[4*r+c] && !col[c]) row[r] = 1'b0;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every key_valid pulse must match the next queued code.
   always @(negedge clk) begin
      if (key_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_pulse: got code %h expected no pulse at %0t", key_code, $time);
         end else begin
            logic [3:0] code;
            code    = exp_q.pop_front();
            m_value = {m_value[27:0], code};
            if (m_cnt != 4'd8) m_cnt = m_cnt + 4'd1;
            check("key_code", 32'(key_code), 32'(code));
            check("value", value, m_value);
            check("digit_cnt", 32'(digit_cnt), 32'(m_cnt));
         end
      end
   end

   task automatic hold(input logic [15:0] k, input int unsigned scans);
      keys = k;
      repeat (scans * SCAN) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clr = 1'b1;
      exp_q.delete();
      m_value = '0;
      m_cnt   = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_col", 32'(col), 32'(4'b1110));
      check("rst_value", value, 32'h0);
      check("rst_digit_cnt", 32'(digit_cnt), 32'h0);
      check("rst_key_valid", 32'(key_valid), 32'h0);
      check("rst_key_code", 32'(key_code), 32'h0);
      @(posedge clk);
      #1;
      clr = 1'b0;
   endtask

   initial begin
      logic [3:0] exp_col;
      n_cmp   = 0;
      n_bad   = 0;
      keys    = '0;
      clr     = 1'b1;
      m_value = '0;
      m_cnt   = '0;

      // Single key r1c2, then the nine-key entry sequence.
      tbl[0] = '{16'h0040, 6, 6, 1'b1, 4'h6};
      tbl[1] = '{16'h0001, 6, 6, 1'b1, 4'h1};
      tbl[2] = '{16'h0002, 6, 6, 1'b1, 4'h2};
      tbl[3] = '{16'h0004, 6, 6, 1'b1, 4'h3};
      tbl[4] = '{16'h0008, 6, 6, 1'b1, 4'hA};
      tbl[5] = '{16'h0010, 6, 6, 1'b1, 4'h4};
      tbl[6] = '{16'h0020, 6, 6, 1'b1, 4'h5};
      tbl[7] = '{16'h0040, 6, 6, 1'b1, 4'h6};
      tbl[8] = '{16'h0080, 6, 6, 1'b1, 4'hB};
      tbl[9] = '{16'h0100, 6, 6, 1'b1, 4'h7};

      @(posedge clk);
      #1;
      do_reset();

      // Column rotation after reset release.
      exp_col = 4'b1110;
      for (int i = 0; i < 4; i++) begin
         repeat (SDIV) @(posedge clk);
         @(negedge clk);
         exp_col = {exp_col[2:0], exp_col[3]};
         check("col_rotate", 32'(col), 32'(exp_col));
      end
      @(posedge clk);
      #1;

      for (int i = 0; i < 10; i++) begin
         if (tbl[i].emit) exp_q.push_back(tbl[i].code);
         hold(tbl[i].keys, tbl[i].press_scans);
         hold(16'h0000, tbl[i].rel_scans);
         check("entry_drain", 32'(exp_q.size()), 32'h0);
      end
      check("entry_value", value, 32'h23A4_56B7);
      check("entry_digits", 32'(digit_cnt), 32'h8);

      // Bounce on r0c0: alternate every scan, then hold steady.
      for (int i = 0; i < 10; i++) begin
         hold((i % 2 == 0) ? 16'h0001 : 16'h0000, 1);
      end
      check("bounce_quiet", 32'(exp_q.size()), 32'h0);
      exp_q.push_back(4'h1);
      hold(16'h0001, 5);
      hold(16'h0000, 6);
      check("bounce_drain", 32'(exp_q.size()), 32'h0);

      // Two keys together, then drop one: only the survivor is emitted.
      hold(16'h0300, 6);
      exp_q.push_back(4'h7);
      hold(16'h0100, 6);
      hold(16'h0100, 6);
      hold(16'h0000, 6);
      check("twokey_drain", 32'(exp_q.size()), 32'h0);

      // Reset in the middle of debouncing r3c1; the held key comes back once.
      keys = 16'h2000;
      repeat (40) @(posedge clk);
      #1;
      do_reset();
      exp_q.push_back(4'h0);
      hold(16'h2000, 6);
      check("midrst_drain", 32'(exp_q.size()), 32'h0);
      hold(16'h0000, 6);
      check("midrst_value", value, 32'h0);
      check("midrst_digits", 32'(digit_cnt), 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
